fan_off_timer: RTL and testbench
================================

Name: fan_off_timer

Overview:
- Auto-off countdown stage that sits directly downstream of the 50 Hz clock divider in the fan controller.
- Counts rising edges of the divided clock, sampled synchronously as a tick, to form one-second steps.
- A button cycles through off-timer presets. The block counts the remaining seconds down and emits a one-cycle expire pulse so that fan control can switch the fan off.
- Remaining seconds are exported for the display stage.

Parameters:
- TICKS_PER_SEC, 50, rising edges of tick_in per second (must be >= 1).
- SEC_W, 8, width of the remaining-seconds counter.
- PRESET1, 30, seconds loaded for preset_sel=1.
- PRESET2, 60, seconds loaded for preset_sel=2.
- PRESET3, 120, seconds loaded for preset_sel=3. All presets must be >= 1 and < 2^SEC_W.

Ports:
- clk_in  in  1  system clock (100 Hz); all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- tick_in  in  1  50 Hz divided clock from the divider, used as data only; each rising edge is one tick.
- fan_on  in  1  level; fan currently running.
- timer_btn  in  1  debounced button level; each rising edge advances the preset.
- remain_sec  out  SEC_W  seconds left; 0 when not running.
- timer_active  out  1  high while in RUN.
- preset_sel  out  2  0=timer off, 1..3 = PRESET1..3.
- expire  out  1  single-cycle pulse at countdown end.

Behaviour:
- Reset is synchronous and active-high: one clock, clk_in; rst is sampled only on clk_in rising edge. rst overrides all other inputs.
- Reset values:
  - state=IDLE, remain_sec=0, sub_cnt=0, preset_sel=0, expire=0, timer_active=0.
  - Edge-detect history registers reset to 1, so a high tick_in or timer_btn at reset release gives no spurious edge.
- Edge detection: tick_p = tick_in & ~tick_q; btn_p = timer_btn & ~btn_q; tick_q and btn_q are registered every cycle.
- Latency: an edge present on cycle N updates the registers at the end of cycle N and becomes visible on cycle N+1.
- sub_cnt is a 0..TICKS_PER_SEC-1 counter, $clog2(TICKS_PER_SEC) bits (minimum 1).
- States: IDLE, RUN, EXPIRE. Outputs are registered, except that timer_active = (state==RUN).
- Priority each cycle, highest first: rst > fan_on==0 > btn_p > tick_p.
- fan_on==0:
  - Any state goes to IDLE with preset_sel=0, remain_sec=0 and sub_cnt=0; expire is not asserted.
  - btn_p is ignored while fan_on==0.
- btn_p with fan_on==1, in any state:
  - preset_sel <= preset_sel+1 mod 4.
  - New sel 0: go to IDLE with remain_sec=0 and sub_cnt=0.
  - New sel 1..3: load remain_sec=PRESETn and sub_cnt=0, go to RUN. This restarts the countdown even mid-run.
  - A tick_p in the same cycle is discarded.
- RUN with tick_p:
  - If sub_cnt<TICKS_PER_SEC-1, sub_cnt+1.
  - Else sub_cnt=0 and remain_sec-1. If remain_sec was 1, remain_sec becomes 0 and the state goes to EXPIRE.
- EXPIRE:
  - expire=1 for exactly this one cycle.
  - Next cycle: IDLE, preset_sel=0, expire=0.
  - A btn_p arriving in the EXPIRE cycle is applied from sel 0, i.e. it selects preset 1 and moves to RUN; expire is still pulsed.
- IDLE: tick_p is ignored and the counters hold at 0.
- No wrap-around: remain_sec never decrements below 0.
- Mid-operation rst returns to reset values on the next edge, with no expire pulse.

Decomposition:
- Package fan_pkg:
  - state enum {IDLE, RUN, EXPIRE}.
  - preset-select encodings SEL_OFF=0 to SEL_3=3.
  - default TICKS_PER_SEC and preset constants, shared with the display and fan control stages.
- Sub-module rise_detect: 1-bit synchronous rising-edge detector with parameterised reset value of the history flop. Instantiate it twice, for tick_in and timer_btn.

Test Plan:
- Bench configuration TICKS_PER_SEC=2, PRESET1/2/3=3/5/7, tick_in toggling every clk_in cycle.
- Reset with tick_in=1 and timer_btn=1 held high -> no state change after release; remain_sec=0, preset_sel=0, expire never asserted.
- fan_on=1, one btn edge -> next cycle preset_sel=1, remain_sec=3, timer_active=1. remain_sec reaches 2, 1, 0 at every 2nd tick edge. expire is high exactly one cycle, coincident with remain_sec=0; the following cycle shows preset_sel=0, timer_active=0.
- Four btn edges spaced 3 cycles apart -> preset_sel 1,2,3,0 and remain_sec 3,5,7,0. After the fourth edge the block stays in IDLE; ticks do not change remain_sec.
- RUN at remain_sec=2, then a btn edge coinciding with a tick edge that would complete a second -> remain_sec=5 (PRESET2), sub_cnt=0, no decrement that cycle.
- RUN at remain_sec=1 with sub_cnt=1, then fan_on dropped on the cycle of the final tick edge -> IDLE, remain_sec=0, preset_sel=0, expire stays 0. A btn edge while fan_on=0 leaves preset_sel=0.
- rst asserted for one cycle mid-RUN (remain_sec=4) -> all outputs at reset values on the next cycle, no expire. With tick_in high at release there is no edge, and the first decrement requires a fresh btn edge.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared definitions for the fan controller: timer FSM states, preset-select
// encodings and the default tick rate / preset lengths.
package fan_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t RUN    = 2'd1;
  localparam state_t EXPIRE = 2'd2;

  typedef logic [1:0] sel_t;
  localparam sel_t SEL_OFF = 2'd0;
  localparam sel_t SEL_1   = 2'd1;
  localparam sel_t SEL_2   = 2'd2;
  localparam sel_t SEL_3   = 2'd3;

  localparam int unsigned DEF_TICKS_PER_SEC = 50;
  localparam int unsigned DEF_SEC_W         = 8;
  localparam int unsigned DEF_PRESET1       = 30;
  localparam int unsigned DEF_PRESET2       = 60;
  localparam int unsigned DEF_PRESET3       = 120;

  // Seconds loaded for a given selection; SEL_OFF maps to 0.
  function automatic int unsigned preset_secs(input sel_t        sel,
                                              input int unsigned p1,
                                              input int unsigned p2,
                                              input int unsigned p3);
    int unsigned secs;
    case (sel)
      SEL_1:   secs = p1;
      SEL_2:   secs = p2;
      SEL_3:   secs = p3;
      default: secs = 0;
    endcase
    return secs;
  endfunction

endpackage

// File: rtl/fan_off_timer_if.sv
// Signal bundle between the fan controller and its auto-off timer stage.
interface fan_off_timer_if
  import fan_pkg::*;
#(
  parameter int unsigned SEC_W = fan_pkg::DEF_SEC_W
);
  logic             tick_in;
  logic             fan_on;
  logic             timer_btn;
  logic [SEC_W-1:0] remain_sec;
  logic             timer_active;
  sel_t             preset_sel;
  logic             expire;

  modport master (
    output tick_in, fan_on, timer_btn,
    input  remain_sec, timer_active, preset_sel, expire
  );

  modport slave (
    input  tick_in, fan_on, timer_btn,
    output remain_sec, timer_active, preset_sel, expire
  );
endinterface

// File: rtl/rise_detect.sv
// One-bit synchronous rising-edge detector; the history flop resets to RST_VAL
// so a level already high at reset release is not reported as an edge.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d_i,
  output logic pulse_o
);
  logic hist_q, hist_d;

  always_comb hist_d = d_i;

  always_ff @(posedge clk_in) begin
    if (rst) hist_q <= RST_VAL;
    else     hist_q <= hist_d;
  end

  assign pulse_o = d_i & ~hist_q;
endmodule

// File: rtl/fan_off_timer.sv
// Auto-off countdown: a button cycles presets, tick edges form one-second
// steps, and a one-cycle expire pulse marks the end of the countdown.
module fan_off_timer
  import fan_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = fan_pkg::DEF_TICKS_PER_SEC,
  parameter int unsigned SEC_W         = fan_pkg::DEF_SEC_W,
  parameter int unsigned PRESET1       = fan_pkg::DEF_PRESET1,
  parameter int unsigned PRESET2       = fan_pkg::DEF_PRESET2,
  parameter int unsigned PRESET3       = fan_pkg::DEF_PRESET3
) (
  input logic           clk_in,
  input logic           rst,
  fan_off_timer_if.slave bus
);
  localparam int unsigned SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);

  logic tick_p, btn_p;

  rise_detect #(.RST_VAL(1'b1)) u_tick_edge (
    .clk_in  (clk_in),
    .rst     (rst),
    .d_i     (bus.tick_in),
    .pulse_o (tick_p)
  );

  rise_detect #(.RST_VAL(1'b1)) u_btn_edge (
    .clk_in  (clk_in),
    .rst     (rst),
    .d_i     (bus.timer_btn),
    .pulse_o (btn_p)
  );

  state_t           state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [SEC_W-1:0] remain_q, remain_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic             expire_q, expire_d;
  sel_t             sel_next;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    remain_d = remain_q;
    sub_d    = sub_q;
    // A press during the expire cycle counts from "off", not from the old preset.
    sel_next = ((state_q == EXPIRE) ? SEL_OFF : sel_q) + 2'd1;

    if (!bus.fan_on) begin
      state_d  = IDLE;
      sel_d    = SEL_OFF;
      remain_d = '0;
      sub_d    = '0;
    end else if (btn_p) begin
      sel_d = sel_next;
      sub_d = '0;
      if (sel_next == SEL_OFF) begin
        state_d  = IDLE;
        remain_d = '0;
      end else begin
        state_d  = RUN;
        remain_d = SEC_W'(preset_secs(sel_next, PRESET1, PRESET2, PRESET3));
      end
    end else begin
      case (state_q)
        RUN: begin
          if (tick_p) begin
            if (sub_q < SUB_MAX) begin
              sub_d = sub_q + SUB_W'(1);
            end else begin
              sub_d = '0;
              if (remain_q != '0) remain_d = remain_q - SEC_W'(1);
              if (remain_q <= SEC_W'(1)) state_d = EXPIRE;
            end
          end
        end
        EXPIRE: begin
          state_d  = IDLE;
          sel_d    = SEL_OFF;
          remain_d = '0;
          sub_d    = '0;
        end
        default: begin
          state_d  = IDLE;
          remain_d = '0;
          sub_d    = '0;
        end
      endcase
    end

    expire_d = (state_d == EXPIRE);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= SEL_OFF;
      remain_q <= '0;
      sub_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      remain_q <= remain_d;
      sub_q    <= sub_d;
      expire_q <= expire_d;
    end
  end

  assign bus.remain_sec   = remain_q;
  assign bus.preset_sel   = sel_q;
  assign bus.expire       = expire_q;
  assign bus.timer_active = (state_q == RUN);
endmodule

// File: tb/tb_fan_off_timer.sv
// Bench for fan_off_timer: directed scenarios plus random stimulus, all checked
// against a tick-budget model of the countdown.
module tb_fan_off_timer;
  localparam int unsigned T = 2;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_in = ~clk_in;

  fan_off_timer_if #(.SEC_W(8)) bus ();

  fan_off_timer #(
    .TICKS_PER_SEC (T),
    .SEC_W         (8),
    .PRESET1       (3),
    .PRESET2       (5),
    .PRESET3       (7)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;
  bit tick_en  = 1'b0;
  bit found;
  int exp_rem[4] = '{0, 3, 5, 7};

  // Model: a countdown is a budget of tick edges; seconds shown = ceil(left / T).
  int m_left, m_sel;
  bit m_run, m_exp, m_ptick, m_pbtn;
  bit tp, bp;

  function automatic int m_preset(input int s);
    case (s)
      1:       return 3;
      2:       return 5;
      3:       return 7;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    if (tick_en) bus.tick_in = ~bus.tick_in;
  endtask

  initial begin
    m_left = 0; m_sel = 0; m_run = 0; m_exp = 0; m_ptick = 1; m_pbtn = 1;
    forever begin
      @(posedge clk_in);
      tp = bus.tick_in && !m_ptick;
      bp = bus.timer_btn && !m_pbtn;
      m_ptick = bus.tick_in;
      m_pbtn  = bus.timer_btn;
      if (rst) begin
        m_ptick = 1; m_pbtn = 1; m_left = 0; m_sel = 0; m_run = 0; m_exp = 0;
      end else if (!bus.fan_on) begin
        m_left = 0; m_sel = 0; m_run = 0; m_exp = 0;
      end else if (bp) begin
        m_sel  = ((m_exp ? 0 : m_sel) + 1) % 4;
        m_exp  = 0;
        m_run  = (m_sel != 0);
        m_left = m_preset(m_sel) * T;
      end else if (m_exp) begin
        m_exp = 0;
        m_sel = 0;
      end else if (m_run && tp) begin
        m_left--;
        if (m_left == 0) begin
          m_run = 0;
          m_exp = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (check_en) begin
        check("model_remain_sec", bus.remain_sec, (m_left + T - 1) / T);
        check("model_preset_sel", bus.preset_sel, m_sel);
        check("model_timer_active", bus.timer_active, m_run);
        check("model_expire", bus.expire, m_exp);
      end
    end
  end

  initial begin
    bus.tick_in = 1'b1; bus.timer_btn = 1'b1; bus.fan_on = 1'b0; rst = 1'b1;
    repeat (3) step();
    check_en = 1'b1;

    // Release reset with tick and button already high: no edges.
    bus.fan_on = 1'b1; rst = 1'b0;
    repeat (4) step();
    check("rst_remain", bus.remain_sec, 0);
    check("rst_sel", bus.preset_sel, 0);
    check("rst_active", bus.timer_active, 0);
    check("rst_expire", bus.expire, 0);
    bus.timer_btn = 1'b0; tick_en = 1'b1;
    repeat (2) step();

    // One press -> preset 1, then count down to expire.
    bus.timer_btn = 1'b1; step(); bus.timer_btn = 1'b0;
    check("load_sel", bus.preset_sel, 1);
    check("load_remain", bus.remain_sec, 3);
    check("load_active", bus.timer_active, 1);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.expire === 1'b1) begin found = 1; break; end
    end
    check("expire_seen", found, 1);
    check("expire_remain", bus.remain_sec, 0);
    step();
    check("post_expire_sel", bus.preset_sel, 0);
    check("post_expire_active", bus.timer_active, 0);
    check("post_expire_pulse", bus.expire, 0);

    // Four presses spaced 3 cycles apart walk 1,2,3,0.
    for (int k = 1; k <= 4; k++) begin
      bus.timer_btn = 1'b1; step(); bus.timer_btn = 1'b0;
      check("cycle_sel", bus.preset_sel, k % 4);
      check("cycle_remain", bus.remain_sec, exp_rem[k % 4]);
      repeat (2) step();
    end
    repeat (6) step();
    check("idle_remain", bus.remain_sec, 0);
    check("idle_active", bus.timer_active, 0);

    // Press on the same cycle as a second-completing tick at remain 2.
    bus.timer_btn = 1'b1; step(); bus.timer_btn = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_left == 3 && bus.tick_in && !m_ptick) begin found = 1; break; end
      step();
    end
    check("align_btn_tick", found, 1);
    bus.timer_btn = 1'b1; step(); bus.timer_btn = 1'b0;
    check("btn_over_tick_remain", bus.remain_sec, 5);
    check("btn_over_tick_sel", bus.preset_sel, 2);

    // Drop fan_on on the cycle of the final tick edge.
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_left == 1 && bus.tick_in && !m_ptick) begin found = 1; break; end
      step();
    end
    check("align_fan_drop", found, 1);
    bus.fan_on = 1'b0; step();
    check("fan_off_remain", bus.remain_sec, 0);
    check("fan_off_sel", bus.preset_sel, 0);
    check("fan_off_active", bus.timer_active, 0);
    check("fan_off_expire", bus.expire, 0);
    step();
    check("fan_off_expire2", bus.expire, 0);
    bus.timer_btn = 1'b1; step();
    check("fan_off_btn_sel", bus.preset_sel, 0);
    bus.timer_btn = 1'b0; step();
    bus.fan_on = 1'b1; step();

    // Reset mid-run at remain 4 with tick high across release.
    bus.timer_btn = 1'b1; step(); bus.timer_btn = 1'b0; repeat (2) step();
    bus.timer_btn = 1'b1; step(); bus.timer_btn = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if ((m_left + 1) / 2 == 4) begin found = 1; break; end
      step();
    end
    check("align_rst", found, 1);
    check("pre_rst_remain", bus.remain_sec, 4);
    tick_en = 1'b0; bus.tick_in = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_remain", bus.remain_sec, 0);
    check("mid_rst_sel", bus.preset_sel, 0);
    check("mid_rst_active", bus.timer_active, 0);
    check("mid_rst_expire", bus.expire, 0);
    repeat (4) step();
    tick_en = 1'b1;
    repeat (4) step();
    check("rst_idle_remain", bus.remain_sec, 0);
    bus.timer_btn = 1'b1; step(); bus.timer_btn = 1'b0;
    check("rst_reload_remain", bus.remain_sec, 3);
    check("rst_reload_active", bus.timer_active, 1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if (bus.fan_on) bus.fan_on = ($urandom_range(0, 149) != 0);
      else            bus.fan_on = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) bus.timer_btn = ~bus.timer_btn;
      rst     = ($urandom_range(0, 499) == 0);
      tick_en = ($urandom_range(0, 9) != 0);
      step();
    end
    rst = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
